// File: rtl/gmsk_timing_pkg.sv
// rtl/gmsk_timing_pkg.sv - GSM TDMA timing constants and slot-length helper
//
// Shared by gmsk_sym_phase_cnt and gmsk_sym_timer. Slots 0 and 4 carry one
// extra guard symbol so that four slots total exactly 625 symbols.
package gmsk_timing_pkg;

    localparam int         SLOTS_PER_FRAME = 8;
    localparam logic [7:0] SLOT_LEN_LONG   = 8'd157;
    localparam logic [7:0] SLOT_LEN_SHORT  = 8'd156;
    localparam logic [2:0] LONG_SLOT_A     = 3'd0;
    localparam logic [2:0] LONG_SLOT_B     = 3'd4;
    localparam int         FN_MOD_DEFAULT  = 2715648;

    function automatic logic [7:0] slot_len(input logic [2:0] ts);
        return ((ts == LONG_SLOT_A) || (ts == LONG_SLOT_B)) ? SLOT_LEN_LONG : SLOT_LEN_SHORT;
    endfunction

endpackage

// File: rtl/gmsk_sym_phase_cnt.sv
// rtl/gmsk_sym_phase_cnt.sv - divisor latch, symbol phase counter and strobes
//
// Ports:
//   clk_in    divided clock, rising edge
//   rst_x     synchronous active-low reset
//   en        run enable; low holds the phase and suppresses strobes
//   div_val   requested clocks per symbol (values below 2 act as 2)
//   resync    restart the phase at 0 and re-latch the divisor
//   sym_tick  combinational: this cycle ends a symbol (registered as sym_stb)
//   sym_stb   registered symbol strobe
//   half_stb  registered mid-symbol strobe
module gmsk_sym_phase_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_x,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             resync,
    output logic             sym_tick,
    output logic             sym_stb,
    output logic             half_stb
);

    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sym_stb_q, sym_stb_d;
    logic             half_stb_q, half_stb_d;
    logic [DIV_W-1:0] div_clamped;

    assign div_clamped = (div_val < DIV_W'(2)) ? DIV_W'(2) : div_val;

    // The divisor only changes at a symbol boundary, so a div_val change
    // mid-symbol never shortens or stretches the symbol already in flight.
    always_comb begin
        phase_d    = phase_q;
        div_d      = div_q;
        sym_stb_d  = 1'b0;
        half_stb_d = 1'b0;
        sym_tick   = 1'b0;
        if (resync) begin
            phase_d = '0;
            div_d   = div_clamped;
        end else if (en) begin
            sym_tick   = (phase_q == div_q - DIV_W'(1));
            sym_stb_d  = sym_tick;
            half_stb_d = (phase_q == (div_q >> 1) - DIV_W'(1));
            if (sym_tick) begin
                phase_d = '0;
                div_d   = div_clamped;
            end else begin
                phase_d = phase_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_x) begin
            phase_q    <= '0;
            div_q      <= DIV_W'(2);
            sym_stb_q  <= 1'b0;
            half_stb_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            div_q      <= div_d;
            sym_stb_q  <= sym_stb_d;
            half_stb_q <= half_stb_d;
        end
    end

    assign sym_stb  = sym_stb_q;
    assign half_stb = half_stb_q;

endmodule

// File: rtl/gmsk_sym_timer.sv
// rtl/gmsk_sym_timer.sv - GMSK symbol strobes and GSM TDMA position tracking
//
// Optional feature macro: GMSK_SYM_TIMER_FN_CMP_EN (adds fn_cmp / fn_hit).
// Ports:
//   clk_in, rst_x        clock and synchronous active-low reset
//   en                   run enable
//   div_val              clocks per symbol
//   resync               restart at fn=0, ts=0, sym=0, phase=0
//   sym_stb, half_stb    single-cycle symbol / mid-symbol strobes
//   sym_idx, ts_idx, fn  TDMA position
//   slot_start           pulse with the first symbol of each slot
//   frame_start          pulse with the first symbol of timeslot 0
//   fn_cmp, fn_hit       (optional) frame-number match pulse
module gmsk_sym_timer
    import gmsk_timing_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int FN_W   = 22,
    parameter int FN_MOD = FN_MOD_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_x,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             resync,
    output logic             sym_stb,
    output logic             half_stb,
    output logic [7:0]       sym_idx,
    output logic [2:0]       ts_idx,
    output logic [FN_W-1:0]  fn,
    output logic             slot_start,
    output logic             frame_start
`ifdef GMSK_SYM_TIMER_FN_CMP_EN
    ,
    input  logic [FN_W-1:0]  fn_cmp,
    output logic             fn_hit
`endif
);

    logic            sym_tick;
    logic [7:0]      sym_q, sym_d;
    logic [2:0]      ts_q, ts_d;
    logic [FN_W-1:0] fn_q, fn_d;
    logic            started_q, started_d;
    logic            slot_start_q, slot_start_d;
    logic            frame_start_q, frame_start_d;

    gmsk_sym_phase_cnt #(
        .DIV_W (DIV_W)
    ) u_phase (
        .clk_in   (clk_in),
        .rst_x    (rst_x),
        .en       (en),
        .div_val  (div_val),
        .resync   (resync),
        .sym_tick (sym_tick),
        .sym_stb  (sym_stb),
        .half_stb (half_stb)
    );

    // started_q clear means the first symbol of the timeline has not yet been
    // emitted: that symbol lands on position 0 instead of advancing it.
    always_comb begin
        sym_d         = sym_q;
        ts_d          = ts_q;
        fn_d          = fn_q;
        started_d     = started_q;
        slot_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (resync) begin
            sym_d     = '0;
            ts_d      = '0;
            fn_d      = '0;
            started_d = 1'b0;
        end else if (sym_tick) begin
            if (!started_q) begin
                started_d     = 1'b1;
                slot_start_d  = 1'b1;
                frame_start_d = 1'b1;
            end else if (sym_q == slot_len(ts_q) - 8'd1) begin
                sym_d        = '0;
                ts_d         = ts_q + 3'd1;
                slot_start_d = 1'b1;
                if (ts_q == 3'(SLOTS_PER_FRAME - 1)) begin
                    frame_start_d = 1'b1;
                    fn_d = (fn_q == FN_W'(FN_MOD - 1)) ? '0 : fn_q + FN_W'(1);
                end
            end else begin
                sym_d = sym_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_x) begin
            sym_q         <= '0;
            ts_q          <= '0;
            fn_q          <= '0;
            started_q     <= 1'b0;
            slot_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            sym_q         <= sym_d;
            ts_q          <= ts_d;
            fn_q          <= fn_d;
            started_q     <= started_d;
            slot_start_q  <= slot_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sym_idx     = sym_q;
    assign ts_idx      = ts_q;
    assign fn          = fn_q;
    assign slot_start  = slot_start_q;
    assign frame_start = frame_start_q;

`ifdef GMSK_SYM_TIMER_FN_CMP_EN
    logic fn_hit_q, fn_hit_d;

    always_comb begin
        fn_hit_d = frame_start_d && (fn_d == fn_cmp);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_x) begin
            fn_hit_q <= 1'b0;
        end else begin
            fn_hit_q <= fn_hit_d;
        end
    end

    assign fn_hit = fn_hit_q;
`endif

endmodule

// File: tb/tb_gmsk_sym_timer.sv
// tb/tb_gmsk_sym_timer.sv - randomized self-checking bench for gmsk_sym_timer
module tb_gmsk_sym_timer;

    localparam int DIV_W     = 8;
    localparam int FN_W      = 22;
    localparam int TB_FN_MOD = 3;
    localparam int FRAME_SYM = 1250;

    logic             clk_in = 1'b0;
    logic             rst_x;
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             resync;
    logic             sym_stb, half_stb;
    logic [7:0]       sym_idx;
    logic [2:0]       ts_idx;
    logic [FN_W-1:0]  fn;
    logic             slot_start, frame_start;
`ifdef GMSK_SYM_TIMER_FN_CMP_EN
    logic [FN_W-1:0]  fn_cmp;
    logic             fn_hit;
`endif

    always #5 clk_in = ~clk_in;

    gmsk_sym_timer #(
        .DIV_W  (DIV_W),
        .FN_W   (FN_W),
        .FN_MOD (TB_FN_MOD)
    ) dut (
        .clk_in      (clk_in),
        .rst_x       (rst_x),
        .en          (en),
        .div_val     (div_val),
        .resync      (resync),
        .sym_stb     (sym_stb),
        .half_stb    (half_stb),
        .sym_idx     (sym_idx),
        .ts_idx      (ts_idx),
        .fn          (fn),
        .slot_start  (slot_start),
        .frame_start (frame_start)
`ifdef GMSK_SYM_TIMER_FN_CMP_EN
        ,
        .fn_cmp      (fn_cmp),
        .fn_hit      (fn_hit)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    // Reference model: elapsed enabled cycles in the current symbol, the
    // divisor governing this symbol, and the count of symbols emitted since
    // the last reset/resync (-1 = none yet). Position is derived arithmetically.
    int     m_el, m_d;
    longint m_k;
    int     e_sym, e_ts, e_fn;
    bit     e_sstb, e_hstb, e_slot, e_frame, e_hit;
    int     slot_hist[$];

    function automatic int slot_len_ref(input int t);
        return (t == 0 || t == 4) ? 157 : 156;
    endfunction

    function automatic int clamp_div(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic compute_pos();
        longint r;
        if (m_k < 0) begin
            e_sym = 0; e_ts = 0; e_fn = 0;
        end else begin
            r    = m_k % FRAME_SYM;
            e_fn = int'((m_k / FRAME_SYM) % TB_FN_MOD);
            e_ts = 0;
            while (r >= slot_len_ref(e_ts)) begin
                r = r - slot_len_ref(e_ts);
                e_ts++;
            end
            e_sym = int'(r);
        end
    endtask

    task automatic model_edge();
        e_sstb = 0; e_hstb = 0; e_slot = 0; e_frame = 0; e_hit = 0;
        if (!rst_x) begin
            m_el = 0; m_d = 2; m_k = -1;
        end else if (resync) begin
            m_el = 0; m_d = clamp_div(int'(div_val)); m_k = -1;
        end else if (en) begin
            m_el++;
            e_hstb = (m_el == m_d / 2);
            if (m_el == m_d) begin
                e_sstb = 1;
                m_el   = 0;
                m_d    = clamp_div(int'(div_val));
                m_k++;
            end
        end
        compute_pos();
        if (e_sstb) begin
            e_slot  = (e_sym == 0);
            e_frame = e_slot && (e_ts == 0);
            if (e_slot) slot_hist.push_back(int'(m_k));
`ifdef GMSK_SYM_TIMER_FN_CMP_EN
            e_hit = e_frame && (e_fn == int'(fn_cmp));
`endif
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        chk("sym_stb", sym_stb, e_sstb);
        chk("half_stb", half_stb, e_hstb);
        chk("sym_idx", sym_idx, e_sym);
        chk("ts_idx", ts_idx, e_ts);
        chk("fn", fn, e_fn);
        chk("slot_start", slot_start, e_slot);
        chk("frame_start", frame_start, e_frame);
`ifdef GMSK_SYM_TIMER_FN_CMP_EN
        chk("fn_hit", fn_hit, e_hit);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int guard;
        rst_x = 1'b0; en = 1'b1; div_val = 8'd48; resync = 1'b0;
`ifdef GMSK_SYM_TIMER_FN_CMP_EN
        fn_cmp = 22'd1;
`endif
        m_el = 0; m_d = 2; m_k = -1;
        run(3);
        rst_x = 1'b1;
        run(200);

        // mid-symbol divisor change
        div_val = 8'd10;
        run(150);

        // 1250+ symbols at D=4 to reach the second frame_start
        div_val = 8'd4; resync = 1'b1;
        step();
        resync = 1'b0;
        slot_hist.delete();
        run(4 * 1260);
        chk("slot_start_count", slot_hist.size(), 9);
        if (slot_hist.size() >= 5) chk("slot4_at", slot_hist[4], 625);

        // enable dropped 7 cycles mid-symbol
        run(1 + $urandom_range(0, 2));
        en = 1'b0;
        run(7);
        en = 1'b1;
        run(40);

        // resync at ts=5, sym=100
        guard = 0;
        while (!(e_ts == 5 && e_sym == 100) && guard < 12000) begin
            step();
            guard++;
        end
        chk("reach_ts5_sym100", guard < 12000, 1);
        resync = 1'b1;
        step();
        resync = 1'b0;
        run(20);

        // div below 2 behaves as 2; run through fn 0,1,2,0
        div_val = 8'($urandom_range(0, 1));
        resync = 1'b1;
        step();
        resync = 1'b0;
        run(2 * FRAME_SYM * 3 + 100);

        // reset wins over resync
        div_val = 8'd9; resync = 1'b1; rst_x = 1'b0;
        step();
        rst_x = 1'b1; resync = 1'b0;
        run(20);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) div_val = 8'($urandom_range(0, 12));
            resync = ($urandom_range(0, 299) == 0);
            step();
        end
        resync = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
